// File: rtl/register_defs.sv
// Mode encodings shared by the universal register
// and its next-state logic.
package register_defs;
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;
endpackage

// File: rtl/ureg_next.sv
// Combinational next-value and flag logic for
// universal_register; masks say which flops update.
module ureg_next
  import register_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rout_i,
  input  logic [WIDTH-1:0] rin_i,
  input  logic             sin_i,
  input  logic [2:0]       mode_i,
  output logic [WIDTH-1:0] nxt_o,
  output logic             sout_o,
  output logic             cout_o,
  output logic             upd_rout_o,
  output logic             upd_sout_o,
  output logic             upd_cout_o
);

  always_comb begin
    nxt_o      = rout_i;
    sout_o     = 1'b0;
    cout_o     = 1'b0;
    upd_rout_o = 1'b0;
    upd_sout_o = 1'b0;
    upd_cout_o = 1'b0;
    unique case (mode_i)
      MODE_HOLD: begin
      end
      MODE_LOAD: begin
        nxt_o      = rin_i;
        upd_rout_o = 1'b1;
        upd_cout_o = 1'b1;
      end
      MODE_SHL: begin
        nxt_o      = {rout_i[WIDTH-2:0], sin_i};
        sout_o     = rout_i[WIDTH-1];
        upd_rout_o = 1'b1;
        upd_sout_o = 1'b1;
      end
      MODE_SHR: begin
        nxt_o      = {sin_i, rout_i[WIDTH-1:1]};
        sout_o     = rout_i[0];
        upd_rout_o = 1'b1;
        upd_sout_o = 1'b1;
      end
      MODE_ROL: begin
        nxt_o      = {rout_i[WIDTH-2:0],
                      rout_i[WIDTH-1]};
        sout_o     = rout_i[WIDTH-1];
        upd_rout_o = 1'b1;
        upd_sout_o = 1'b1;
      end
      MODE_ROR: begin
        nxt_o      = {rout_i[0],
                      rout_i[WIDTH-1:1]};
        sout_o     = rout_i[0];
        upd_rout_o = 1'b1;
        upd_sout_o = 1'b1;
      end
      MODE_INC: begin
        nxt_o      = rout_i + 1'b1;
        cout_o     = &rout_i;
        upd_rout_o = 1'b1;
        upd_cout_o = 1'b1;
      end
      MODE_DEC: begin
        nxt_o      = rout_i - 1'b1;
        cout_o     = ~|rout_i;
        upd_rout_o = 1'b1;
        upd_cout_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/universal_register.sv
// WIDTH-bit register with load, shift, rotate and
// inc/dec modes plus registered sout/cout/zero flags.
module universal_register
  import register_defs::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] Rin,
  input  logic             sin,
  output logic [WIDTH-1:0] Rout,
  output logic             sout,
  output logic             cout,
  output logic             zero
);

  localparam logic RST_ZERO = (RESET_VAL == '0);

  logic [WIDTH-1:0] rout_q, rout_d, nxt;
  logic             sout_q, sout_d, nxt_sout;
  logic             cout_q, cout_d, nxt_cout;
  logic             zero_q, zero_d;
  logic             upd_rout, upd_sout, upd_cout;

  ureg_next #(.WIDTH(WIDTH)) u_next (
    .rout_i     (rout_q),
    .rin_i      (Rin),
    .sin_i      (sin),
    .mode_i     (mode),
    .nxt_o      (nxt),
    .sout_o     (nxt_sout),
    .cout_o     (nxt_cout),
    .upd_rout_o (upd_rout),
    .upd_sout_o (upd_sout),
    .upd_cout_o (upd_cout)
  );

  always_comb begin
    rout_d = rout_q;
    sout_d = sout_q;
    cout_d = cout_q;
    if (clr) begin
      rout_d = RESET_VAL;
      sout_d = 1'b0;
      cout_d = 1'b0;
    end else if (en) begin
      if (upd_rout) rout_d = nxt;
      if (upd_sout) sout_d = nxt_sout;
      if (upd_cout) cout_d = nxt_cout;
    end
    // zero tracks the value being written, so no lag
    zero_d = (rout_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rout_q <= RESET_VAL;
      sout_q <= 1'b0;
      cout_q <= 1'b0;
      zero_q <= RST_ZERO;
    end else begin
      rout_q <= rout_d;
      sout_q <= sout_d;
      cout_q <= cout_d;
      zero_q <= zero_d;
    end
  end

  assign Rout = rout_q;
  assign sout = sout_q;
  assign cout = cout_q;
  assign zero = zero_q;

endmodule
